// File: rtl/tia_pkg.sv
// Shared constants for the TIA player graphics serializer: NUSIZ stretch codes,
// scale width, FSM encoding and the NUSIZ-to-scale decode.
package tia_pkg;

   localparam logic [2:0] NZ_DOUBLE = 3'b101;
   localparam logic [2:0] NZ_QUAD   = 3'b111;
   localparam int         SCALE_W   = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   // Number of pixel clocks each graphics bit is held for.
   function automatic logic [SCALE_W-1:0] scale_of(input logic [2:0] nz);
      case (nz)
         NZ_DOUBLE: return 3'd2;
         NZ_QUAD:   return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/tia_player_scan_divider.sv
// Pixel-stretch counter: counts pck edges within one graphics bit and strobes
// advance on the last stretch pixel of that bit.
module tia_player_scan_divider
   import tia_pkg::*;
(
   input  logic       motck,
   input  logic       rst,
   input  logic       pck,
   input  logic       clear,
   input  logic       run,
   input  logic [2:0] nz,
   output logic       advance
);

   logic [SCALE_W-1:0] sub_reg;
   logic [SCALE_W-1:0] sub_next;
   logic [SCALE_W-1:0] last_sub;

   // Greater-or-equal so a scale shrink mid-scan terminates the bit instead of wrapping.
   always_comb begin
      last_sub = scale_of(nz) - 3'd1;
      advance  = run && pck && (sub_reg >= last_sub);
      sub_next = sub_reg;
      if (pck) begin
         if (clear) begin
            sub_next = '0;
         end else if (run) begin
            sub_next = advance ? '0 : sub_reg + 3'd1;
         end
      end
   end

   always_ff @(posedge motck) begin
      if (rst) begin
         sub_reg <= '0;
      end else begin
         sub_reg <= sub_next;
      end
   end

endmodule

// File: rtl/tia_player_graphics_serializer.sv
// TIA player graphics serializer: shifts out 8 graphics bits, each stretched by the
// NUSIZ scale. Define TIA_PLAYER_REFLECT_EN to honour refp (LSB-first when set).
module tia_player_graphics_serializer
   import tia_pkg::*;
(
   input  logic       motck,
   input  logic       rst,
   input  logic       pck,
   input  logic       start_bar,
   input  logic       nz0_bar,
   input  logic       nz1_bar,
   input  logic       nz2_bar,
   input  logic [7:0] grp_d,
   input  logic       grp_we,
   input  logic       grp_old_we,
   input  logic       vdel,
   input  logic       refp,
   output logic       p,
   output logic       scanning
);

   state_t      state_reg, state_next;
   logic [2:0]  bit_idx_reg, bit_idx_next;
   logic        p_reg, p_next;
   logic [7:0]  grp_new_reg, grp_old_reg;
   logic [7:0]  src;
   logic [2:0]  sel;
   logic [2:0]  nz;
   logic        start_scan;
   logic        advance;

   assign nz  = ~{nz2_bar, nz1_bar, nz0_bar};
   assign src = vdel ? grp_old_reg : grp_new_reg;

`ifdef TIA_PLAYER_REFLECT_EN
   assign sel = refp ? bit_idx_reg : 3'd7 - bit_idx_reg;
`else
   logic unused_refp;
   assign unused_refp = refp;
   assign sel         = 3'd7 - bit_idx_reg;
`endif

   tia_player_scan_divider u_divider (
      .motck   (motck),
      .rst     (rst),
      .pck     (pck),
      .clear   (start_scan),
      .run     (state_reg == ST_SCAN),
      .nz      (nz),
      .advance (advance)
   );

   always_comb begin
      state_next   = state_reg;
      bit_idx_next = bit_idx_reg;
      p_next       = p_reg;
      start_scan   = 1'b0;
      if (pck) begin
         case (state_reg)
            ST_IDLE: begin
               p_next = 1'b0;
               if (!start_bar) begin
                  state_next   = ST_SCAN;
                  bit_idx_next = 3'd0;
                  start_scan   = 1'b1;
               end
            end
            ST_SCAN: begin
               p_next = src[sel];
               if (advance) begin
                  if (bit_idx_reg == 3'd7) begin
                     state_next   = ST_IDLE;
                     bit_idx_next = 3'd0;
                  end else begin
                     bit_idx_next = bit_idx_reg + 3'd1;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Graphics writes ignore pck; a simultaneous write pair moves the pre-write value to old.
   always_ff @(posedge motck) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         bit_idx_reg <= 3'd0;
         p_reg       <= 1'b0;
         grp_new_reg <= 8'h00;
         grp_old_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         bit_idx_reg <= bit_idx_next;
         p_reg       <= p_next;
         if (grp_old_we) begin
            grp_old_reg <= grp_new_reg;
         end
         if (grp_we) begin
            grp_new_reg <= grp_d;
         end
      end
   end

   assign p        = p_reg;
   assign scanning = (state_reg == ST_SCAN);

endmodule

// File: tb/tb_tia_player_graphics_serializer.sv
// Directed self-checking bench for tia_player_graphics_serializer; expectations
// follow the TIA_PLAYER_REFLECT_EN setting of the build.
module tb_tia_player_graphics_serializer;

   logic       motck = 1'b0;
   logic       rst;
   logic       pck;
   logic       start_bar;
   logic       nz0_bar, nz1_bar, nz2_bar;
   logic [7:0] grp_d;
   logic       grp_we;
   logic       grp_old_we;
   logic       vdel;
   logic       refp;
   logic       p;
   logic       scanning;

   int errors = 0;
   int checks = 0;

   always #5 motck = ~motck;

   tia_player_graphics_serializer dut (
      .motck      (motck),
      .rst        (rst),
      .pck        (pck),
      .start_bar  (start_bar),
      .nz0_bar    (nz0_bar),
      .nz1_bar    (nz1_bar),
      .nz2_bar    (nz2_bar),
      .grp_d      (grp_d),
      .grp_we     (grp_we),
      .grp_old_we (grp_old_we),
      .vdel       (vdel),
      .refp       (refp),
      .p          (p),
      .scanning   (scanning)
   );

   task automatic tick();
      @(posedge motck);
      #1;
   endtask

   task automatic set_nz(input logic [2:0] nz);
      {nz2_bar, nz1_bar, nz0_bar} = ~nz;
   endtask

   task automatic load_new(input logic [7:0] d);
      grp_d  = d;
      grp_we = 1'b1;
      tick();
      grp_we = 1'b0;
   endtask

   task automatic start_pulse();
      start_bar = 1'b0;
      tick();
      start_bar = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; grp_d = 8'hFF; grp_we = 1'b1; grp_old_we = 1'b1; start_bar = 1'b0;
      tick(); tick();
      checks++;
      if (p !== 1'b0 || scanning !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: p=%b scanning=%b required p=0 scanning=0", p, scanning);
      end
      rst = 1'b0; grp_we = 1'b0; grp_old_we = 1'b0; start_bar = 1'b1;
      tick();
      start_pulse();
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (p !== 1'b0) begin
            errors++;
            $display("FAIL reset_grp_clear pix%0d: p=%b required 0", k, p);
         end
      end
      tick();
   endtask

   task automatic test_msb_first();
      logic [7:0] g;
      g = 8'hA5;
      set_nz(3'b000);
      load_new(g);
      start_pulse();
      checks++;
      if (scanning !== 1'b1 || p !== 1'b0) begin
         errors++;
         $display("FAIL msb_start_edge: p=%b scanning=%b required p=0 scanning=1", p, scanning);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (p !== g[7-k] || scanning !== (k < 7)) begin
            errors++;
            $display("FAIL msb_first pix%0d: p=%b scanning=%b required p=%b scanning=%b",
                     k, p, scanning, g[7-k], (k < 7));
         end
      end
      tick();
      checks++;
      if (p !== 1'b0) begin
         errors++;
         $display("FAIL msb_after_scan: p=%b required 0", p);
      end
   endtask

   task automatic test_double();
      set_nz(3'b101);
      load_new(8'h80);
      start_pulse();
      for (int k = 0; k < 16; k++) begin
         tick();
         checks++;
         if (p !== (k < 2) || scanning !== (k < 15)) begin
            errors++;
            $display("FAIL double pix%0d: p=%b scanning=%b required p=%b scanning=%b",
                     k, p, scanning, (k < 2), (k < 15));
         end
      end
      tick();
   endtask

   task automatic test_quad_reflect();
      logic exp_p;
      set_nz(3'b111);
      refp = 1'b1;
      load_new(8'h01);
      start_pulse();
      for (int k = 0; k < 32; k++) begin
         tick();
`ifdef TIA_PLAYER_REFLECT_EN
         exp_p = (k < 4);
`else
         exp_p = (k >= 28);
`endif
         checks++;
         if (p !== exp_p || scanning !== (k < 31)) begin
            errors++;
            $display("FAIL quad_reflect pix%0d: p=%b scanning=%b required p=%b scanning=%b",
                     k, p, scanning, exp_p, (k < 31));
         end
      end
      refp = 1'b0;
      tick();
   endtask

   task automatic test_vdel();
      set_nz(3'b000);
      load_new(8'hFF);
      grp_old_we = 1'b1; tick(); grp_old_we = 1'b0;
      load_new(8'h00);
      for (int v = 1; v >= 0; v--) begin
         vdel = v[0];
         start_pulse();
         for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (p !== v[0]) begin
               errors++;
               $display("FAIL vdel%0d pix%0d: p=%b required %b", v, k, p, v[0]);
            end
         end
         tick();
      end
      vdel = 1'b0;
   endtask

   task automatic test_simultaneous_we();
      logic [7:0] g;
      g = 8'h3C;
      load_new(g);
      grp_d = 8'hC3; grp_we = 1'b1; grp_old_we = 1'b1;
      tick();
      grp_we = 1'b0; grp_old_we = 1'b0;
      vdel = 1'b1;
      start_pulse();
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (p !== g[7-k]) begin
            errors++;
            $display("FAIL simul_we pix%0d: p=%b required %b", k, p, g[7-k]);
         end
      end
      vdel = 1'b0;
      tick();
   endtask

   task automatic test_restart_ignored();
      logic [7:0] g;
      g = 8'hA5;
      load_new(g);
      start_pulse();
      for (int k = 0; k < 8; k++) begin
         start_bar = !(k == 3 || k == 7);
         tick();
         checks++;
         if (p !== g[7-k]) begin
            errors++;
            $display("FAIL restart_ignored pix%0d: p=%b required %b", k, p, g[7-k]);
         end
      end
      start_bar = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (p !== (k == 0 ? g[0] : 1'b0) || scanning !== 1'b0) begin
            errors++;
            $display("FAIL restart_after%0d: p=%b scanning=%b required p=%b scanning=0",
                     k, p, scanning, (k == 0 ? g[0] : 1'b0));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_scan();
      load_new(8'hFF);
      start_pulse();
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (p !== 1'b0 || scanning !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_scan: p=%b scanning=%b required p=0 scanning=0", p, scanning);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (p !== 1'b0 || scanning !== 1'b0) begin
            errors++;
            $display("FAIL reset_after%0d: p=%b scanning=%b required p=0 scanning=0",
                     k, p, scanning);
         end
      end
   endtask

   task automatic test_scale_change();
      set_nz(3'b111);
      load_new(8'h80);
      start_pulse();
      for (int k = 0; k < 11; k++) begin
         if (k == 3) set_nz(3'b000);
         tick();
         checks++;
         if (p !== (k < 4) || scanning !== (k < 10)) begin
            errors++;
            $display("FAIL scale_change pix%0d: p=%b scanning=%b required p=%b scanning=%b",
                     k, p, scanning, (k < 4), (k < 10));
         end
      end
      tick();
   endtask

   task automatic test_pck_gated();
      logic [7:0] g;
      logic       prev;
      g = 8'hA5;
      set_nz(3'b000);
      load_new(g);
      pck = 1'b0; start_bar = 1'b0;
      tick();
      checks++;
      if (scanning !== 1'b0) begin
         errors++;
         $display("FAIL gated_no_start: scanning=%b required 0", scanning);
      end
      pck = 1'b1;
      tick();
      start_bar = 1'b1;
      prev = 1'b0;
      for (int k = 0; k < 8; k++) begin
         pck = 1'b0;
         for (int h = 0; h < 2; h++) begin
            tick();
            checks++;
            if (p !== prev || scanning !== 1'b1) begin
               errors++;
               $display("FAIL gated_hold pix%0d.%0d: p=%b scanning=%b required p=%b scanning=1",
                        k, h, p, scanning, prev);
            end
         end
         pck = 1'b1;
         tick();
         checks++;
         if (p !== g[7-k]) begin
            errors++;
            $display("FAIL gated_pix%0d: p=%b required %b", k, p, g[7-k]);
         end
         prev = g[7-k];
      end
      tick();
      checks++;
      if (p !== 1'b0 || scanning !== 1'b0) begin
         errors++;
         $display("FAIL gated_end: p=%b scanning=%b required p=0 scanning=0", p, scanning);
      end
   endtask

   initial begin
      rst = 1'b1; pck = 1'b1; start_bar = 1'b1;
      nz0_bar = 1'b1; nz1_bar = 1'b1; nz2_bar = 1'b1;
      grp_d = 8'h00; grp_we = 1'b0; grp_old_we = 1'b0;
      vdel = 1'b0; refp = 1'b0;
      test_reset();
      test_msb_first();
      test_double();
      test_quad_reflect();
      test_vdel();
      test_simultaneous_we();
      test_restart_ignored();
      test_reset_mid_scan();
      test_scale_change();
      test_pck_gated();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tia_player_graphics_serializer.md
TIA_PLAYER_GRAPHICS_SERIALIZER -- requirements
Module: tia_player_graphics_serializer

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
  motck        in   1  master motion clock; all state changes on its rising edge.
  rst          in   1  reset, synchronous, active-high.
  pck          in   1  player pixel-clock enable; state advances only on motck edges with pck=1.
  start_bar    in   1  active-low scan-start request from the player position counter.
  nz0_bar      in   1  NUSIZ bit 0, inverted.
  nz1_bar      in   1  NUSIZ bit 1, inverted.
  nz2_bar      in   1  NUSIZ bit 2, inverted.
  grp_d        in   8  graphics data bus.
  grp_we       in   1  load grp_d into the new-graphics register.
  grp_old_we   in   1  copy the new-graphics register into the old-graphics register.
  vdel         in   1  vertical delay: 1 selects old graphics for serialization.
  refp         in   1  reflect: 1 serializes bit 0 first.
  p            out  1  serialized player pixel.
  scanning     out  1  high while a scan is in progress.

Function
REQ-002 SHALL derive the scale from nz = ~{nz2_bar,nz1_bar,nz0_bar}: 3'b101 gives 2 pck per bit, 3'b111 gives 4 pck per bit, all other codes give 1.
REQ-003 SHALL use two states, IDLE and SCAN.
REQ-004 IDLE->SCAN on a pck=1 edge with start_bar=0; on that edge bit_idx<=0, sub<=0, p<=0.
REQ-005 On each pck=1 edge in SCAN, p SHALL take src[7-bit_idx] when refp=0 and src[bit_idx] when refp=1; src = vdel ? grp_old : grp_new.
REQ-006 The same edge SHALL increment sub; when sub reaches scale-1, sub SHALL clear and bit_idx SHALL increment.
REQ-007 SCAN->IDLE on the edge that outputs bit_idx=7 with sub=scale-1, for exactly 8*scale pixels per scan.
REQ-008 On pck=1 edges in IDLE, p SHALL be 0.
REQ-009 On pck=0 edges, p, state and counters SHALL hold.
REQ-010 Latency: the first pixel SHALL appear on the first pck=1 edge after the start edge.
REQ-011 start_bar=0 during SCAN SHALL be ignored.
REQ-012 start_bar=0 on the terminating edge SHALL NOT start a new scan; the next scan needs a later pck=1 edge with start_bar=0.
REQ-013 nz, vdel and refp SHALL be sampled live each pck edge; a change of scale mid-scan SHALL take effect at the next sub comparison, with no sub overflow (sub>=scale-1 counts as terminal).
REQ-014 grp_we and grp_old_we SHALL act on every motck edge regardless of pck.
REQ-015 When grp_we and grp_old_we are high together, grp_old SHALL receive the pre-write grp_new value.
REQ-016 Output p SHALL be registered; scanning SHALL be high exactly when state is SCAN.

Reset
REQ-017 rst=1 SHALL force on the next edge: state=IDLE, p=0, scanning=0, bit_idx=0, sub=0, grp_new=0, grp_old=0; rst SHALL take priority over all inputs.
REQ-018 Reset asserted mid-scan SHALL abort the scan; no pixel SHALL be emitted until a fresh start after rst deasserts.

Configuration
REQ-019 Macro TIA_PLAYER_REFLECT_EN defined: refp behaves per REQ-005.
REQ-020 Macro TIA_PLAYER_REFLECT_EN undefined: refp is ignored and serialization is always MSB-first; the port remains present.

Structure
REQ-021 Package tia_pkg SHALL hold the NUSIZ code constants (double=3'b101, quad=3'b111), the scale width, and the state encoding.
REQ-022 The pixel-stretch counter (sub and scale decode) SHALL be a sub-module tia_player_scan_divider, which outputs an advance strobe.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
  1. grp=8'hA5, nz=000, pck every cycle, start pulse -> p=1,0,1,0,0,1,0,1 on the next 8 pck edges, then 0.
  2. grp=8'h80, nz=101 -> p high for 2 pck, low for 14 pck; scanning high for 16 pck.
  3. grp=8'h01, nz=111, refp=1 -> p high for the first 4 pck of 32.
     Without TIA_PLAYER_REFLECT_EN -> p high for the last 4 pck.
  4. grp_we with 8'hFF, then grp_old_we, then grp_we with 8'h00, vdel=1 -> scan outputs 8 ones; vdel=0 -> 8 zeros.
  5. Second start_bar pulse at scan pixel 3 -> ignored, exactly 8 pixels.
     rst at pixel 4 -> p=0 next edge, scanning=0.
  6. pck high every 3rd motck -> output identical to scenario 1, each pixel held 3 motck.
